// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared types, limits and helpers for the multiport register file.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package regfile_pkg;

  // Sweep controller states: clearing storage, or open for normal traffic.
  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  // Upper limits on port counts supported by the generate structure.
  localparam int c_max_nr = 4;
  localparam int c_max_nw = 2;

  // Storage index width for a given depth; never narrower than one bit.
  function automatic int rf_addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_bank.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bank
// Brief    : One storage copy: NW write ports, one asynchronous read port.
//            No reset; addresses arrive already range-checked by the top.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int IW    = rf_addr_w(DEPTH),
  parameter int NW    = 1
) (
  input  logic               clk,
  input  logic [NW-1:0]      we,
  input  logic [NW*IW-1:0]   waddr,
  input  logic [NW*XLEN-1:0] wdata,
  input  logic [IW-1:0]      raddr,
  output logic [XLEN-1:0]    rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];

  // Write all enabled ports; later loop iterations overwrite earlier ones,
  // so the highest-index port wins on an address collision.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NW; k++) begin
      if (we[k]) begin
        r_mem[waddr[k*IW +: IW]] <= wdata[k*XLEN +: XLEN];
      end
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport
// Brief    : Parametrised multi-read/multi-write register file with a
//            sequential clear sweep on reset, optional zero register,
//            write-to-read bypass and optional registered read.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 32,
  parameter int AW        = $clog2(DEPTH),
  parameter int NR        = 2,
  parameter int NW        = 1,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int SYNC_READ = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               busy,
  input  logic [NR*AW-1:0]   raddr,
  output logic [NR*XLEN-1:0] rdata,
  input  logic [NW-1:0]      wen,
  input  logic [NW*AW-1:0]   waddr,
  input  logic [NW*XLEN-1:0] wdata
);

  localparam int            IW      = rf_addr_w(DEPTH);
  localparam logic [IW-1:0] c_last  = IW'(DEPTH - 1);
  localparam logic [AW:0]   c_depth = (AW + 1)'(DEPTH);

  // Configuration sanity checks, evaluated at elaboration.
  if (NR < 1 || NR > c_max_nr) begin : g_chk_nr
    $error("regfile_multiport: NR out of range");
  end
  if (NW < 1 || NW > c_max_nw) begin : g_chk_nw
    $error("regfile_multiport: NW out of range");
  end
  if (DEPTH < 2 || AW < IW) begin : g_chk_depth
    $error("regfile_multiport: DEPTH < 2 or AW too narrow for DEPTH");
  end

  rf_state_t     r_state;
  rf_state_t     w_state_nxt;
  logic [IW-1:0] r_sweep;
  logic [IW-1:0] w_sweep_nxt;
  logic          w_clr_we;
  logic          w_busy;

  logic [NW-1:0]      w_wacc;
  logic [NW-1:0]      w_bank_we;
  logic [NW*IW-1:0]   w_bank_waddr;
  logic [NW*XLEN-1:0] w_bank_wdata;

  // Sweep state register; rst is folded into the next-state logic.
  always_ff @(posedge clk) begin
    r_state <= w_state_nxt;
    r_sweep <= w_sweep_nxt;
  end

  // Next-state: hold in CLEAR at index 0 under reset, otherwise walk every
  // entry once and drop into READY after the last one is cleared.
  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_clr_we    = 1'b0;
    if (rst) begin
      w_state_nxt = RF_CLEAR;
      w_sweep_nxt = '0;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          w_clr_we = 1'b1;
          if (r_sweep == c_last) begin
            w_state_nxt = RF_READY;
            w_sweep_nxt = '0;
          end else begin
            w_sweep_nxt = r_sweep + 1'b1;
          end
        end
        RF_READY: begin
          w_state_nxt = RF_READY;
        end
        default: begin
          w_state_nxt = RF_CLEAR;
          w_sweep_nxt = '0;
        end
      endcase
    end
  end

  assign w_busy = rst || (r_state != RF_READY);
  assign busy   = w_busy;

  // Write acceptance: READY only, in range, and never into a hardwired zero.
  for (genvar k = 0; k < NW; k++) begin : g_wacc
    logic [AW-1:0] w_wa;
    assign w_wa      = waddr[k*AW +: AW];
    assign w_wacc[k] = !w_busy && wen[k] && ({1'b0, w_wa} < c_depth) &&
                       !((ZERO_REG != 0) && (w_wa == '0));
  end

  // Bank write ports: the sweep borrows port 0 while clearing, otherwise the
  // accepted writeback ports pass straight through.
  always_comb begin
    w_bank_we    = w_wacc;
    w_bank_waddr = '0;
    w_bank_wdata = '0;
    for (int k = 0; k < NW; k++) begin
      w_bank_waddr[k*IW +: IW]     = waddr[k*AW +: IW];
      w_bank_wdata[k*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
    end
    if (w_clr_we) begin
      w_bank_we               = '0;
      w_bank_we[0]            = 1'b1;
      w_bank_waddr[0 +: IW]   = r_sweep;
      w_bank_wdata[0 +: XLEN] = '0;
    end
  end

  // One private storage copy per read port, plus its read-side logic.
  for (genvar p = 0; p < NR; p++) begin : g_rport
    logic [AW-1:0]   w_ra;
    logic            w_rinr;
    logic [IW-1:0]   w_bank_ra;
    logic [XLEN-1:0] w_bank_rd;
    logic [XLEN-1:0] w_rval;

    assign w_ra      = raddr[p*AW +: AW];
    assign w_rinr    = ({1'b0, w_ra} < c_depth) &&
                       !((ZERO_REG != 0) && (w_ra == '0));
    // Out-of-range reads look up entry 0 so the bank is never indexed past
    // its end; the result is masked below anyway.
    assign w_bank_ra = w_rinr ? w_ra[IW-1:0] : '0;

    regfile_bank #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .IW    (IW),
      .NW    (NW)
    ) u_bank (
      .clk   (clk),
      .we    (w_bank_we),
      .waddr (w_bank_waddr),
      .wdata (w_bank_wdata),
      .raddr (w_bank_ra),
      .rdata (w_bank_rd)
    );

    // Read value: zero when busy/masked, else storage, overridden by an
    // accepted same-cycle write (highest matching port last, so it wins).
    always_comb begin
      w_rval = '0;
      if (!w_busy && w_rinr) begin
        w_rval = w_bank_rd;
        if (BYPASS != 0) begin
          for (int k = 0; k < NW; k++) begin
            if (w_wacc[k] && (waddr[k*AW +: AW] == w_ra)) begin
              w_rval = wdata[k*XLEN +: XLEN];
            end
          end
        end
      end
    end

    if (SYNC_READ != 0) begin : g_sync
      logic [XLEN-1:0] r_rdata;
      // Registered read; cleared for the whole reset/sweep window.
      always_ff @(posedge clk) begin
        if (w_busy) begin
          r_rdata <= '0;
        end else begin
          r_rdata <= w_rval;
        end
      end
      assign rdata[p*XLEN +: XLEN] = r_rdata;
    end else begin : g_comb
      assign rdata[p*XLEN +: XLEN] = w_rval;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_multiport
// Brief    : Directed scoreboard bench over four register-file configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_d;

  // A: defaults (NR2 NW1 ZERO BYPASS comb)
  logic [9:0]  a_raddr;  logic [63:0] a_rdata;  logic [0:0] a_wen;
  logic [4:0]  a_waddr;  logic [31:0] a_wdata;  logic       a_busy;
  // B: NW2, no bypass, comb read
  logic [9:0]  b_raddr;  logic [63:0] b_rdata;  logic [1:0] b_wen;
  logic [9:0]  b_waddr;  logic [63:0] b_wdata;  logic       b_busy;
  // C: NR1, registered read, no bypass
  logic [4:0]  c_raddr;  logic [31:0] c_rdata;  logic [0:0] c_wen;
  logic [4:0]  c_waddr;  logic [31:0] c_wdata;  logic       c_busy;
  // D: DEPTH24 AW5, NR1 NW2, bypass, own reset
  logic [4:0]  d_raddr;  logic [31:0] d_rdata;  logic [1:0] d_wen;
  logic [9:0]  d_waddr;  logic [63:0] d_wdata;  logic       d_busy;

  regfile_multiport u_a (
    .clk(clk), .rst(rst), .busy(a_busy), .raddr(a_raddr), .rdata(a_rdata),
    .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata));

  regfile_multiport #(.NW(2), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .busy(b_busy), .raddr(b_raddr), .rdata(b_rdata),
    .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata));

  regfile_multiport #(.NR(1), .BYPASS(0), .SYNC_READ(1)) u_c (
    .clk(clk), .rst(rst), .busy(c_busy), .raddr(c_raddr), .rdata(c_rdata),
    .wen(c_wen), .waddr(c_waddr), .wdata(c_wdata));

  regfile_multiport #(.DEPTH(24), .AW(5), .NR(1), .NW(2)) u_d (
    .clk(clk), .rst(rst_d), .busy(d_busy), .raddr(d_raddr), .rdata(d_rdata),
    .wen(d_wen), .waddr(d_waddr), .wdata(d_wdata));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int na, nd;

  initial begin
    rst = 1'b1; rst_d = 1'b1;
    a_raddr = '0; a_wen = '0; a_waddr = '0; a_wdata = '0;
    b_raddr = '0; b_wen = '0; b_waddr = '0; b_wdata = '0;
    c_raddr = '0; c_wen = '0; c_waddr = '0; c_wdata = '0;
    d_raddr = '0; d_wen = '0; d_waddr = '0; d_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    push("rst_busy_a", 32'd1);     check({31'b0, a_busy});
    push("rst_rdata0_a", 32'd0);   check(a_rdata[31:0]);
    push("rst_rdata1_a", 32'd0);   check(a_rdata[63:32]);
    push("rst_rdata_c", 32'd0);    check(c_rdata);
    push("rst_busy_d", 32'd1);     check({31'b0, d_busy});

    // Sweep length and write suppression during the sweep
    rst = 1'b0; rst_d = 1'b0;
    a_wen = 1'b1; a_waddr = 5'd5; a_wdata = 32'h0000DEAD;
    a_raddr = {5'd5, 5'd5};
    push("sweep_rdata_a", 32'd0);
    push("sweep_len_a", 32'd32);
    push("sweep_len_d", 32'd24);
    na = 0; nd = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_busy) na++;
      if (d_busy) nd++;
      if (i == 3) check(a_rdata[31:0]);
      if (!a_busy) break;
    end
    check(na);
    check(nd);
    a_wen = 1'b0;
    #1;
    push("sweep_write_ignored", 32'd0); check(a_rdata[31:0]);

    // Every address reads zero after the sweep
    for (int i = 0; i < 32; i++) begin
      a_raddr = {5'(31 - i), 5'(i)};
      push("clear_p0", 32'd0);
      push("clear_p1", 32'd0);
      #1;
      check(a_rdata[31:0]);
      check(a_rdata[63:32]);
    end
    tick();

    // Basic write then read on both ports; zero register
    a_wen = 1'b1; a_waddr = 5'd7; a_wdata = 32'h12345678;
    tick();
    a_wen = 1'b0; a_raddr = {5'd7, 5'd7};
    push("rd7_p0", 32'h12345678);
    push("rd7_p1", 32'h12345678);
    #1;
    check(a_rdata[31:0]);
    check(a_rdata[63:32]);
    a_wen = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFFFFFF; a_raddr = {5'd0, 5'd0};
    push("zero_bypass", 32'd0);
    #1;
    check(a_rdata[31:0]);
    tick();
    a_wen = 1'b0;
    push("zero_p0", 32'd0);
    push("zero_p1", 32'd0);
    #1;
    check(a_rdata[31:0]);
    check(a_rdata[63:32]);

    // Bypass on A: same-cycle write visible, non-matching port unaffected
    a_wen = 1'b1; a_waddr = 5'd9; a_wdata = 32'h00000055;
    tick();
    a_wdata = 32'hA5A5A5A5; a_raddr = {5'd8, 5'd9};
    push("bypass_hit", 32'hA5A5A5A5);
    push("bypass_miss", 32'd0);
    #1;
    check(a_rdata[31:0]);
    check(a_rdata[63:32]);
    tick();
    a_wen = 1'b0;
    push("bypass_written", 32'hA5A5A5A5);
    #1;
    check(a_rdata[31:0]);

    // No bypass on B: old value until the next cycle
    b_wen = 2'b01; b_waddr = {5'd0, 5'd9}; b_wdata = {32'h0, 32'h00000055};
    tick();
    b_wdata = {32'h0, 32'hA5A5A5A5}; b_raddr = {5'd0, 5'd9};
    push("nobypass_old", 32'h00000055);
    #1;
    check(b_rdata[31:0]);
    tick();
    b_wen = 2'b00;
    push("nobypass_new", 32'hA5A5A5A5);
    #1;
    check(b_rdata[31:0]);

    // Two write ports on one address: port 1 wins
    b_wen = 2'b11; b_waddr = {5'd3, 5'd3}; b_wdata = {32'h22, 32'h11};
    b_raddr = {5'd0, 5'd3};
    push("nw2_nobypass_old", 32'd0);
    #1;
    check(b_rdata[31:0]);
    tick();
    b_wen = 2'b00;
    push("nw2_priority", 32'h22);
    #1;
    check(b_rdata[31:0]);

    d_wen = 2'b11; d_waddr = {5'd3, 5'd3}; d_wdata = {32'h22, 32'h11}; d_raddr = 5'd3;
    push("nw2_bypass", 32'h22);
    #1;
    check(d_rdata);
    tick();
    d_wen = 2'b00;
    push("nw2_bypass_written", 32'h22);
    #1;
    check(d_rdata);

    // Registered read, read-before-write
    c_wen = 1'b1; c_waddr = 5'd4; c_wdata = 32'h1; c_raddr = 5'd4;
    tick();
    push("sync_first", 32'd0);
    check(c_rdata);
    c_wdata = 32'h2;
    tick();
    push("sync_old", 32'h1);
    check(c_rdata);
    c_wen = 1'b0;
    tick();
    push("sync_new", 32'h2);
    check(c_rdata);

    // D: restart the sweep at index 10
    rst_d = 1'b1;
    tick();
    rst_d = 1'b0;
    repeat (10) tick();
    rst_d = 1'b1;
    #1;
    push("restart_busy", 32'd1);
    check({31'b0, d_busy});
    tick();
    rst_d = 1'b0;
    push("restart_len", 32'd24);
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!d_busy) break;
      nd++;
    end
    check(nd);
    d_raddr = 5'd3;
    push("restart_cleared", 32'd0);
    #1;
    check(d_rdata);
    tick();

    // D: out-of-range write dropped, last entry usable, reg0 protected
    d_wen = 2'b01; d_waddr = {5'd0, 5'd30}; d_wdata = {32'h0, 32'hBAD0BAD0}; d_raddr = 5'd30;
    push("oor_bypass", 32'd0);
    #1;
    check(d_rdata);
    tick();
    d_wen = 2'b00;
    push("oor_read", 32'd0);
    #1;
    check(d_rdata);
    d_wen = 2'b11; d_waddr = {5'd23, 5'd0}; d_wdata = {32'h00002323, 32'h77777777};
    d_raddr = 5'd23;
    push("last_bypass", 32'h00002323);
    #1;
    check(d_rdata);
    tick();
    d_wen = 2'b00;
    push("last_written", 32'h00002323);
    #1;
    check(d_rdata);
    d_raddr = 5'd0;
    push("d_zero", 32'd0);
    #1;
    check(d_rdata);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
